// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: instruction width,
// the NOP pattern used for bubbles/flushes, the default reset PC and the
// fetch-state encoding.
package mips_pipe_pkg;

  localparam int INSTR_W = 32;

  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] FS_FETCH   = 2'd0;
  localparam logic [1:0] FS_SKID    = 2'd1;
  localparam logic [1:0] FS_DISCARD = 2'd2;

  typedef enum logic [1:0] {
    FETCH   = FS_FETCH,
    SKID    = FS_SKID,
    DISCARD = FS_DISCARD
  } fetch_state_e;

  // PC arithmetic is plain 32-bit modulo; no alignment is enforced.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding buffer used when a fetch completes while
// the IF/ID register is stalled. clear wins over load, load over unload.
module if_skid_buf
  import mips_pipe_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic               full_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_q, pc_d;

  // Next-state for the single entry.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign full_o  = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Handshake: imem_req/imem_ready form a valid/ready pair -- a fetch completes
// on a rising edge where both are 1; while imem_req=1 and imem_ready=0 the
// address is held stable. The request may be withdrawn only by reset.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetch_cnt/perf_bubble_cnt.
// dbg_fetch_state exposes the fetch FSM state (FS_* encoding).
module if_fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = mips_pipe_pkg::DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_stall,
  input  logic               ID_branch_taken,
  input  logic [31:0]        ID_mux2_out,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] IFID_instruction_out,
  output logic [31:0]        IFID_PCnext_out,
  output logic               IFID_valid_out,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt,
`endif
  output logic [1:0]         dbg_fetch_state
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        target_pc_q, target_pc_d;
  logic               live_q;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [31:0]        ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               ifid_load_valid;

  logic               skid_load, skid_unload, skid_clear, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  logic fire;
  logic accept;

  // live_q keeps the request low until the first edge after reset release.
  assign imem_req  = live_q && (state_q != SKID);
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req && imem_ready;
  assign accept    = !hazard_stall || !ifid_valid_q;

  if_skid_buf u_skid (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_rdata),
    .pc_i     (fetch_pc_q),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc),
    .full_o   (skid_full)
  );

  // Fetch FSM next state, PC update and IF/ID load decisions.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    target_pc_d     = target_pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_load_valid = 1'b0;
    skid_load       = 1'b0;
    skid_unload     = 1'b0;
    skid_clear      = 1'b0;

    if (ID_branch_taken) begin
      // Redirect beats stall: flush IF/ID and the skid entry.
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'h0;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      case (state_q)
        FETCH: begin
          if (fire || !imem_req) begin
            fetch_pc_d = ID_mux2_out;
          end else begin
            // Request in flight: let it finish, then drop its data.
            target_pc_d = ID_mux2_out;
            state_d     = DISCARD;
          end
        end
        SKID: begin
          fetch_pc_d = ID_mux2_out;
          state_d    = FETCH;
        end
        DISCARD: begin
          if (fire) begin
            fetch_pc_d = ID_mux2_out;
            state_d    = FETCH;
          end else begin
            target_pc_d = ID_mux2_out;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (fire) begin
            fetch_pc_d = pc_plus4(fetch_pc_q);
            if (accept) begin
              ifid_instr_d    = imem_rdata;
              ifid_pc_d       = fetch_pc_q;
              ifid_valid_d    = 1'b1;
              ifid_load_valid = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = SKID;
            end
          end else if (accept) begin
            // ID consumed what it held and nothing new arrived.
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = 32'h0;
            ifid_valid_d = 1'b0;
          end
        end
        SKID: begin
          if (!hazard_stall) begin
            if (skid_full) begin
              ifid_instr_d    = skid_instr;
              ifid_pc_d       = skid_pc;
              ifid_valid_d    = 1'b1;
              ifid_load_valid = 1'b1;
              skid_unload     = 1'b1;
            end
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (accept) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = 32'h0;
            ifid_valid_d = 1'b0;
          end
          if (fire) begin
            fetch_pc_d = target_pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      target_pc_q  <= RESET_PC;
      live_q       <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      target_pc_q  <= target_pc_d;
      live_q       <= 1'b1;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_bubble_q;

  // Performance counters: valid loads into IF/ID and bubble cycles; both wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      if (ifid_load_valid) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (!ifid_valid_q)   perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

  assign IFID_instruction_out = ifid_instr_q;
  assign IFID_PCnext_out      = ifid_pc_q;
  assign IFID_valid_out       = ifid_valid_q;
  assign dbg_fetch_state      = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps for reset, streaming, stall/skid,
// redirect cases and PC wrap, then a randomized phase checked against a
// program-order model (ID must see consecutive PCs, restarting at each
// taken-branch target).
module tb_if_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default reset PC
  logic        rst, hazard_stall, ID_branch_taken, imem_ready, imem_req;
  logic [31:0] ID_mux2_out, imem_addr, imem_rdata, IFID_instruction_out, IFID_PCnext_out;
  logic        IFID_valid_out;
  logic [1:0]  dbg_a;
  // DUT B: reset PC near the top of the address space
  logic        rst_b, stall_b, br_b, ready_b, req_b;
  logic [31:0] tgt_b, addr_b, rdata_b, instr_b, pc_b;
  logic        valid_b;
  logic [1:0]  dbg_b;
`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_a, pb_a, pf_b, pb_b;
`endif

  int tests = 0;
  int fails = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory contents are a fixed function of the address.
  assign imem_rdata = mem_of(imem_addr);
  assign rdata_b    = mem_of(addr_b);

  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .ID_branch_taken(ID_branch_taken),
    .ID_mux2_out(ID_mux2_out), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .IFID_instruction_out(IFID_instruction_out), .IFID_PCnext_out(IFID_PCnext_out),
    .IFID_valid_out(IFID_valid_out),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(pf_a), .perf_bubble_cnt(pb_a),
`endif
    .dbg_fetch_state(dbg_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst_b), .hazard_stall(stall_b), .ID_branch_taken(br_b),
    .ID_mux2_out(tgt_b), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rdata(rdata_b), .imem_ready(ready_b),
    .IFID_instruction_out(instr_b), .IFID_PCnext_out(pc_b),
    .IFID_valid_out(valid_b),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(pf_b), .perf_bubble_cnt(pb_b),
`endif
    .dbg_fetch_state(dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'h0, IFID_valid_out}, 32'h1);
    check({tag, "_pc"}, IFID_PCnext_out, pc);
    check({tag, "_instr"}, IFID_instruction_out, mem_of(pc));
  endtask

  task automatic check_flushed(input string tag);
    check({tag, "_valid"}, {31'h0, IFID_valid_out}, 32'h0);
    check({tag, "_instr"}, IFID_instruction_out, 32'h0);
    check({tag, "_pc"}, IFID_PCnext_out, 32'h0);
  endtask

  initial begin
    logic        prev_req, prev_ready, rnd_br, rnd_stall;
    logic [31:0] prev_addr, rnd_tgt, nxt;

    rst = 1'b0; hazard_stall = 1'b0; ID_branch_taken = 1'b0; ID_mux2_out = 32'h0; imem_ready = 1'b0;
    rst_b = 1'b0; stall_b = 1'b0; br_b = 1'b0; tgt_b = 32'h0; ready_b = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_flushed("rst");
    check("rst_req", {31'h0, imem_req}, 32'h0);

    // Zero-wait stream from 0
    rst = 1'b1; imem_ready = 1'b1;
    step();
    check("rel_req", {31'h0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_ifid("stream", 32'(4 * k));
    end

    // Reset mid-stream acts immediately
    rst = 1'b0;
    #1;
    check_flushed("mid_rst");
    check("mid_rst_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rel2_req", {31'h0, imem_req}, 32'h1);
    check("rel2_addr", imem_addr, 32'h0);

    // Stall with a response arriving -> skid, no refetch
    step(); check_ifid("pre_stall0", 32'h0);
    step(); check_ifid("pre_stall4", 32'h4);
    hazard_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_ifid("stall_hold", 32'h4);
      check("stall_req", {31'h0, imem_req}, 32'h0);
    end
    hazard_stall = 1'b0;
    step();
    check_ifid("unskid", 32'h8);
    check("unskid_addr", imem_addr, 32'hC);
    check("unskid_req", {31'h0, imem_req}, 32'h1);
    step();
    check_ifid("after_skid", 32'hC);

    // Redirect while a request waits
    imem_ready = 1'b0;
    step();
    check("wait_addr", imem_addr, 32'h10);
    ID_branch_taken = 1'b1; ID_mux2_out = 32'h100;
    step();
    check_flushed("redir_wait");
    check("discard_addr", imem_addr, 32'h10);
    ID_branch_taken = 1'b0;
    step();
    check("discard_hold", imem_addr, 32'h10);
    check("discard_valid", {31'h0, IFID_valid_out}, 32'h0);
    imem_ready = 1'b1;
    step();
    check("tgt_addr", imem_addr, 32'h100);
    check("drop_valid", {31'h0, IFID_valid_out}, 32'h0);
    step();
    check_ifid("tgt_ifid", 32'h100);

    // Redirect and stall together: redirect wins
    hazard_stall = 1'b1; ID_branch_taken = 1'b1; ID_mux2_out = 32'h40;
    step();
    check_flushed("redir_stall");
    check("redir_stall_addr", imem_addr, 32'h40);
    hazard_stall = 1'b0; ID_branch_taken = 1'b0;
    step();
    check_ifid("redir_stall_ifid", 32'h40);

    // Randomized phase against the program-order model
    exp_q.delete();
    exp_q.push_back(32'h40);
    prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0;
    for (int c = 0; c < 600; c++) begin
      if (prev_req && !prev_ready) begin
        check("hold_req", {31'h0, imem_req}, 32'h1);
        check("hold_addr", imem_addr, prev_addr);
      end
      rnd_stall = ($urandom_range(0, 9) < 2);
      rnd_br    = ($urandom_range(0, 19) == 0);
      rnd_tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) rnd_tgt[1:0] = 2'b00;
      imem_ready      = ($urandom_range(0, 9) < 7);
      hazard_stall    = rnd_stall;
      ID_branch_taken = rnd_br;
      ID_mux2_out     = rnd_tgt;
      if (rnd_br) begin
        exp_q.delete();
        exp_q.push_back(rnd_tgt);
      end else if (IFID_valid_out && !rnd_stall) begin
        check("rnd_pc", IFID_PCnext_out, exp_q[0]);
        check("rnd_instr", IFID_instruction_out, mem_of(exp_q[0]));
        nxt = exp_q.pop_front();
        exp_q.push_back(nxt + 32'd4);
        consumed++;
      end
      prev_req = imem_req; prev_ready = imem_ready; prev_addr = imem_addr;
      step();
    end
    hazard_stall = 1'b0; ID_branch_taken = 1'b0;
    check("rnd_progress", {31'h0, consumed > 100}, 32'h1);

    // PC wrap on the second instance
    rst_b = 1'b1;
    step();
    check("wrap_req", {31'h0, req_b}, 32'h1);
    check("wrap_addr", addr_b, 32'hFFFF_FFF8);
    step();
    check("wrap_pc0", pc_b, 32'hFFFF_FFF8);
    check("wrap_instr0", instr_b, mem_of(32'hFFFF_FFF8));
    step();
    check("wrap_pc1", pc_b, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", pc_b, 32'h0000_0000);
    check("wrap_valid", {31'h0, valid_b}, 32'h1);
    check("wrap_next_addr", addr_b, 32'h0000_0004);
`ifdef IF_PERF_CNT_EN
    check("wrap_perf_fetch", pf_b, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
